dec2_4: RTL and testbench
=========================

Name: dec2_4

Overview:
- 2-to-4 one-hot decoder with active-high enable; the leaf building block of the register-file write-select tree.
- dec4_16 is built from five instances: one on sel[3:2], and four on sel[1:0] whose enables are that first stage's outputs.
- The primary output is purely combinational so instances can be cascaded within a single cycle.
- A registered copy of the decode is also provided for pipelined consumers, clocked by the single design clock.

Parameters:
- None. Widths are fixed: sel is 2 bits, out is 4 bits.

Ports:
- clk  input  1  design clock; used only by the registered output out_q
- reset  input  1  synchronous, active-high reset; clears out_q only
- en  input  1  decode enable, active high
- sel  input  2  binary select index 0..3
- out  output  4  combinational one-hot decode; out[k] = en AND (sel == k)
- out_q  output  4  out registered on rising clk; 1-cycle latency

Behaviour:
- Combinational path (out):
  - Zero latency. No clock or reset dependence.
  - en=0: out = 4'b0000 regardless of sel.
  - en=1, sel=0 -> 0001; sel=1 -> 0010; sel=2 -> 0100; sel=3 -> 1000.
  - At most one bit is high at any time. Exactly one bit is high when en=1.
  - Bit ordering is fixed: out[3] corresponds to sel=3. Cascading parents rely on this (parent out[3] enables the child driving bits [15:12]).
  - X/Z on en or sel: out may be X. No X-masking is required.
  - Must be glitch-tolerant for use as an enable. No latches are permitted: implement as a full case with a default of 0000.
- Registered path (out_q):
  - On each rising clk edge with reset=1: out_q <= 4'b0000.
  - On each rising clk edge with reset=0: out_q <= current value of out.
  - After reset, out_q = 0000 until the first non-reset edge.
  - Reset asserted mid-operation clears out_q at the next edge. It has no effect on out.
  - Reset and en=1 together on the same edge: reset wins, out_q = 0000.
  - out_q is always one-hot or all-zero, because it is a sampled copy of out.
- No internal state other than the 4-bit out_q register. No handshake.

Test Plan:
- en=0; sweep sel 0..3, 10 time units each -> out = 0000 at every step; out_q = 0000 after the next clock edge.
- en=1; sweep sel 0,1,2,3 -> out = 0001, 0010, 0100, 1000, each immediately (same timestep). Check $onehot(out) at every step.
- Registered latency: reset=1 for 2 cycles, then reset=0, en=1, sel=2 applied before an edge -> out_q = 0000 before that edge, 0100 after it. Change sel to 1 -> out updates immediately to 0010; out_q follows one edge later.
- Reset priority: hold en=1, sel=3 with out_q = 1000; assert reset for one edge -> out_q = 0000 while out stays 1000. Deassert reset -> out_q = 1000 at the next edge.
- Enable toggle mid-sweep: en=1, sel=1 (out=0010) -> drop en to 0 -> out = 0000 in the same timestep. Raise en again -> out = 0010.
- Cascade check: build the 4-to-16 structure from five instances and sweep en over {0,1} and sel over 0..15 -> out16 = 0 when en=0, and (1 << sel) when en=1, for all 32 combinations.

Source files
------------

// File: rtl/dec2_4.sv
// 2-to-4 one-hot decoder with active-high enable: combinational out for
// same-cycle cascading, plus a registered copy out_q for pipelined consumers.
module dec2_4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] out,
    output logic [3:0] out_q
);

    // Full case with an all-zero default keeps this free of latches; bit k
    // must track sel==k because cascading parents map out[3] to the top child.
    always_comb begin
        out = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    out = 4'b0001;
                2'd1:    out = 4'b0010;
                2'd2:    out = 4'b0100;
                2'd3:    out = 4'b1000;
                default: out = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= 4'b0000;
        else       out_q <= out;
    end

endmodule

// File: tb/tb_dec2_4.sv
// Scoreboard bench for dec2_4: expected values are queued when stimulus is
// driven and popped when the combinational or registered output is sampled.
module tb_dec2_4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] sel;
    logic [3:0] out;
    logic [3:0] out_q;

    int errors = 0;
    int checks = 0;

    logic [3:0]  exp_q[$];
    logic [15:0] exp16_q[$];

    dec2_4 dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    // 4-to-16 cascade: one stage on sel[3:2] enabling four stages on sel[1:0]
    logic        c_en;
    logic [3:0]  c_sel;
    logic [3:0]  c_hi;
    logic [3:0]  c_hi_q;
    logic [15:0] c_out;
    logic [15:0] c_out_q;

    dec2_4 u_hi (
        .clk   (clk),
        .reset (reset),
        .en    (c_en),
        .sel   (c_sel[3:2]),
        .out   (c_hi),
        .out_q (c_hi_q)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lo
        dec2_4 u_lo (
            .clk   (clk),
            .reset (reset),
            .en    (c_hi[g]),
            .sel   (c_sel[1:0]),
            .out   (c_out[g*4 +: 4]),
            .out_q (c_out_q[g*4 +: 4])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] model(input logic e, input logic [1:0] s);
        logic [3:0] m;
        m = 4'b0001;
        m = m << s;
        return e ? m : 4'b0000;
    endfunction

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b1; en = 1'b1; sel = 2'd3;
        #1;
        checks++;
        if (out !== 4'b1000) begin
            errors++;
            $display("FAIL reset_out: got %b want %b", out, 4'b1000);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4'b0000);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if (out_q !== exp) begin
                errors++;
                $display("FAIL reset_out_q: got %b want %b", out_q, exp);
            end
        end
    endtask

    task automatic test_disabled();
        logic [3:0] exp;
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            #1;
            checks++;
            if (out !== 4'b0000) begin
                errors++;
                $display("FAIL disabled_out sel=%0d: got %b want 0000", s, out);
            end
            exp_q.push_back(4'b0000);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if (out_q !== exp) begin
                errors++;
                $display("FAIL disabled_out_q sel=%0d: got %b want %b", s, out_q, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enabled();
        logic [3:0] exp;
        logic [3:0] want;
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel  = s[1:0];
            want = model(1'b1, s[1:0]);
            exp_q.push_back(want);
            #1;
            checks++;
            if (out !== want) begin
                errors++;
                $display("FAIL enabled_out sel=%0d: got %b want %b", s, out, want);
            end
            checks++;
            if (!$onehot(out)) begin
                errors++;
                $display("FAIL enabled_onehot sel=%0d: got %b want one-hot", s, out);
            end
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if (out_q !== exp) begin
                errors++;
                $display("FAIL enabled_out_q sel=%0d: got %b want %b", s, out_q, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; en = 1'b1; sel = 2'd2;
        exp_q.push_back(4'b0100);
        #1;
        checks++;
        if (out_q !== 4'b0000) begin
            errors++;
            $display("FAIL latency_before_edge: got %b want 0000", out_q);
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if (out_q !== exp) begin
            errors++;
            $display("FAIL latency_after_edge: got %b want %b", out_q, exp);
        end
        @(negedge clk);
        sel = 2'd1;
        exp_q.push_back(4'b0010);
        #1;
        checks++;
        if (out !== 4'b0010) begin
            errors++;
            $display("FAIL latency_out_immediate: got %b want 0010", out);
        end
        checks++;
        if (out_q !== 4'b0100) begin
            errors++;
            $display("FAIL latency_out_q_held: got %b want 0100", out_q);
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if (out_q !== exp) begin
            errors++;
            $display("FAIL latency_out_q_follow: got %b want %b", out_q, exp);
        end
    endtask

    task automatic test_reset_priority();
        logic [3:0] exp;
        @(negedge clk);
        en = 1'b1; sel = 2'd3;
        exp_q.push_back(4'b1000);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if (out_q !== exp) begin
            errors++;
            $display("FAIL prio_setup: got %b want %b", out_q, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(4'b0000);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if (out_q !== exp) begin
            errors++;
            $display("FAIL prio_reset_wins: got %b want %b", out_q, exp);
        end
        checks++;
        if (out !== 4'b1000) begin
            errors++;
            $display("FAIL prio_out_unaffected: got %b want 1000", out);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(4'b1000);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if (out_q !== exp) begin
            errors++;
            $display("FAIL prio_release: got %b want %b", out_q, exp);
        end
    endtask

    task automatic test_enable_toggle();
        @(negedge clk);
        en = 1'b1; sel = 2'd1;
        #1;
        checks++;
        if (out !== 4'b0010) begin
            errors++;
            $display("FAIL toggle_on: got %b want 0010", out);
        end
        en = 1'b0;
        #1;
        checks++;
        if (out !== 4'b0000) begin
            errors++;
            $display("FAIL toggle_off: got %b want 0000", out);
        end
        en = 1'b1;
        #1;
        checks++;
        if (out !== 4'b0010) begin
            errors++;
            $display("FAIL toggle_reon: got %b want 0010", out);
        end
    endtask

    task automatic test_cascade();
        logic [15:0] exp;
        logic [15:0] one;
        for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < 16; s++) begin
                c_en  = e[0];
                c_sel = s[3:0];
                one   = 16'h0001;
                exp16_q.push_back(e[0] ? (one << s) : 16'h0000);
                #1;
                exp = exp16_q.pop_front();
                checks++;
                if (c_out !== exp) begin
                    errors++;
                    $display("FAIL cascade en=%0d sel=%0d: got %h want %h", e, s, c_out, exp);
                end
            end
        end
    endtask

    initial begin
        c_en = 1'b0; c_sel = 4'd0;
        test_reset();
        test_disabled();
        test_enabled();
        test_latency();
        test_reset_priority();
        test_enable_toggle();
        test_cascade();
        checks++;
        if (exp_q.size() != 0 || exp16_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0",
                     exp_q.size(), exp16_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
